reg_writeback: RTL and testbench

Write-back stage for the RV64 core, sitting directly upstream of the integer register file and driving its destination index, write data and write enable. It accepts one result per cycle from execute, holds at most one outstanding load while waiting for the memory response, and sign- or zero-extends load data before the write. It also publishes the destination of the pending load so decode can stall on a read-after-write hazard.

---
 rtl/reg_writeback.sv | 140 ++++++++++++++
 tb/tb_reg_writeback.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Purpose  : RV64 write-back stage. Registers ALU results into the integer
//            register file write port, tracks one outstanding load, and
//            sign/zero-extends the returned lane before writing it back.
//            Publishes the pending load destination for RAW stall detection.
// Options  : WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output counting
//            every cycle in which rf_wen is asserted.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,          // synchronous, active-low
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [RW-1:0]   ex_rd,
  input  logic            ex_wen,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_load_fmt,
  input  logic [2:0]      ex_byte_off,
  input  logic            mem_rvalid,
  output logic            mem_rready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wen,
  output logic [RW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy_valid,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]     retire_cnt,
`endif
  output logic [RW-1:0]   busy_rd
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t          state;

  // Captured attributes of the single outstanding load
  logic [RW-1:0]   ld_rd;
  logic            ld_wen;
  logic [2:0]      ld_fmt;
  logic [2:0]      ld_off;

  // Candidate lanes picked out of the aligned doubleword
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [31:0]     word_lane;
  logic [XLEN-1:0] load_ext;

  // Handshakes follow state directly; both are held low while in reset
  assign ex_ready   = rst && (state == IDLE);
  assign mem_rready = rst && (state == WAIT_MEM);

  // Lane extraction: half ignores off[0], word ignores off[1:0]
  assign byte_lane = 8'(mem_rdata >> {ld_off, 3'b000});
  assign half_lane = 16'(mem_rdata >> {ld_off[2:1], 4'b0000});
  assign word_lane = 32'(mem_rdata >> {ld_off[2], 5'b00000});

  // Extend the selected lane according to funct3; 011 and 111 take the full doubleword
  always_comb begin
    load_ext = mem_rdata;
    case (ld_fmt)
      3'b000:  load_ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{(XLEN-16){half_lane[15]}}, half_lane};
      3'b010:  load_ext = {{(XLEN-32){word_lane[31]}}, word_lane};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_lane};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_lane};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, word_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Control FSM with registered write-port and busy outputs; rf_wen is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      busy_valid <= 1'b0;
      busy_rd    <= '0;
      ld_rd      <= '0;
      ld_wen     <= 1'b0;
      ld_fmt     <= 3'b000;
      ld_off     <= 3'b000;
    end else begin
      rf_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (ex_is_load) begin
              ld_rd      <= ex_rd;
              ld_wen     <= ex_wen;
              ld_fmt     <= ex_load_fmt;
              ld_off     <= ex_byte_off;
              busy_valid <= 1'b1;
              busy_rd    <= ex_rd;
              state      <= WAIT_MEM;
            end else begin
              rf_wen   <= ex_wen && (ex_rd != '0);
              rf_rd    <= ex_rd;
              rf_wdata <= ex_result;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            rf_wen     <= ld_wen && (ld_rd != '0);
            rf_rd      <= ld_rd;
            rf_wdata   <= load_ext;
            busy_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count retired writes; natural wrap at 2^64
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (rf_wen) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback
// Purpose  : Self-checking bench for reg_writeback: directed ALU and load
//            cases, randomized traffic against a byte-level load model,
//            reset interaction, and the optional retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [63:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_load_fmt;
  logic [2:0]  ex_byte_off;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [63:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic        busy_valid;
  logic [4:0]  busy_rd;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  reg_writeback #(.XLEN(64), .RW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd      (ex_rd),
    .ex_wen     (ex_wen),
    .ex_result  (ex_result),
    .ex_is_load (ex_is_load),
    .ex_load_fmt(ex_load_fmt),
    .ex_byte_off(ex_byte_off),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rdata  (mem_rdata),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .busy_valid (busy_valid),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .busy_rd    (busy_rd)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load result: access size from funct3, naturally aligned lane,
  // then sign or zero extension computed arithmetically
  function automatic logic [63:0] ref_load(input logic [2:0] fmt, input logic [2:0] off,
                                           input logic [63:0] rdata);
    int nbytes;
    int start;
    logic [63:0] mask;
    logic [63:0] val;
    case (fmt)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2, 3'd6: nbytes = 4;
      default:    nbytes = 8;
    endcase
    start = (int'(off) / nbytes) * nbytes;
    val   = rdata >> (start * 8);
    if (nbytes == 8) return rdata;
    mask = (64'd1 << (nbytes * 8)) - 64'd1;
    val  = val & mask;
    if (fmt < 3'd4 && val[nbytes*8-1]) val = val | ~mask;
    return val;
  endfunction

  task automatic idle_inputs();
    ex_valid    = 1'b0;
    ex_rd       = 5'd0;
    ex_wen      = 1'b0;
    ex_result   = 64'd0;
    ex_is_load  = 1'b0;
    ex_load_fmt = 3'd0;
    ex_byte_off = 3'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 64'd0;
  endtask

  // Issue one load, wait the given cycles, respond, and check the write-back
  task automatic do_load(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [2:0] fmt, input logic [2:0] off,
                         input logic [63:0] rdata, input int waits);
    logic [63:0] exp;
    exp = ref_load(fmt, off, rdata);
    ex_valid    = 1'b1;
    ex_is_load  = 1'b1;
    ex_rd       = rd;
    ex_wen      = wen;
    ex_load_fmt = fmt;
    ex_byte_off = off;
    ex_result   = {$urandom, $urandom};
    step();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check({tag, ".busy_valid"}, {63'd0, busy_valid}, 64'd1);
      check({tag, ".busy_rd"}, {59'd0, busy_rd}, {59'd0, rd});
      check({tag, ".ex_ready"}, {63'd0, ex_ready}, 64'd0);
      check({tag, ".mem_rready"}, {63'd0, mem_rready}, 64'd1);
      check({tag, ".wait_wen"}, {63'd0, rf_wen}, 64'd0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    check({tag, ".busy_last"}, {63'd0, busy_valid}, 64'd1);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    check({tag, ".rf_wen"}, {63'd0, rf_wen}, {63'd0, wen && (rd != 5'd0)});
    check({tag, ".rf_rd"}, {59'd0, rf_rd}, {59'd0, rd});
    check({tag, ".rf_wdata"}, rf_wdata, exp);
    check({tag, ".busy_clr"}, {63'd0, busy_valid}, 64'd0);
    check({tag, ".ready_back"}, {63'd0, ex_ready}, 64'd1);
    step();
    check({tag, ".pulse"}, {63'd0, rf_wen}, 64'd0);
  endtask

  initial begin
    logic        exp_wen;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;
    logic        exp_acc;

    idle_inputs();
    rst = 1'b0;
    step();
    step();
    check("rst.rf_wen", {63'd0, rf_wen}, 64'd0);
    check("rst.rf_rd", {59'd0, rf_rd}, 64'd0);
    check("rst.rf_wdata", rf_wdata, 64'd0);
    check("rst.busy_valid", {63'd0, busy_valid}, 64'd0);
    check("rst.busy_rd", {59'd0, busy_rd}, 64'd0);
    check("rst.ex_ready", {63'd0, ex_ready}, 64'd0);
    check("rst.mem_rready", {63'd0, mem_rready}, 64'd0);
    rst = 1'b1;
    #1;
    check("post_rst.ex_ready", {63'd0, ex_ready}, 64'd1);
    check("post_rst.mem_rready", {63'd0, mem_rready}, 64'd0);

    // Single ALU result
    ex_valid = 1'b1; ex_rd = 5'd5; ex_wen = 1'b1; ex_result = 64'h1234;
    step();
    ex_valid = 1'b0;
    check("alu.rf_wen", {63'd0, rf_wen}, 64'd1);
    check("alu.rf_rd", {59'd0, rf_rd}, 64'd5);
    check("alu.rf_wdata", rf_wdata, 64'h1234);
    step();
    check("alu.pulse", {63'd0, rf_wen}, 64'd0);

    // Back-to-back to rd 1, 0, 2
    ex_valid = 1'b1; ex_rd = 5'd1; ex_result = 64'hA1;
    step();
    check("b2b.wen0", {63'd0, rf_wen}, 64'd1);
    check("b2b.ready0", {63'd0, ex_ready}, 64'd1);
    ex_rd = 5'd0; ex_result = 64'hA2;
    step();
    check("b2b.wen1", {63'd0, rf_wen}, 64'd0);
    check("b2b.ready1", {63'd0, ex_ready}, 64'd1);
    ex_rd = 5'd2; ex_result = 64'hA3;
    step();
    ex_valid = 1'b0;
    check("b2b.wen2", {63'd0, rf_wen}, 64'd1);
    check("b2b.rd2", {59'd0, rf_rd}, 64'd2);
    check("b2b.data2", rf_wdata, 64'hA3);
    check("b2b.ready2", {63'd0, ex_ready}, 64'd1);

    // mem_rvalid while idle must be ignored
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    check("idle_rvalid.rready", {63'd0, mem_rready}, 64'd0);
    step();
    step();
    mem_rvalid = 1'b0;
    check("idle_rvalid.wen", {63'd0, rf_wen}, 64'd0);
    check("idle_rvalid.busy", {63'd0, busy_valid}, 64'd0);

    // Randomized ALU stream
    for (int i = 0; i < 40; i++) begin
      ex_valid  = 1'($urandom_range(0, 3) != 0);
      ex_rd     = 5'($urandom);
      ex_wen    = 1'($urandom);
      ex_result = {$urandom, $urandom};
      exp_acc   = ex_valid;
      exp_wen   = ex_valid && ex_wen && (ex_rd != 5'd0);
      exp_rd    = ex_rd;
      exp_data  = ex_result;
      step();
      check("rnd_alu.wen", {63'd0, rf_wen}, {63'd0, exp_wen});
      if (exp_acc) begin
        check("rnd_alu.rd", {59'd0, rf_rd}, {59'd0, exp_rd});
        check("rnd_alu.data", rf_wdata, exp_data);
      end
    end
    ex_valid = 1'b0;
    step();

    // Directed loads
    do_load("lb3", 5'd9, 1'b1, 3'b000, 3'd3, 64'h00000000_80FF0000, 3);
    do_load("lhu5", 5'd10, 1'b1, 3'b101, 3'd5, 64'h8765_4321_F00D_BEEF, 0);
    do_load("lwu4", 5'd11, 1'b1, 3'b110, 3'd4, 64'h8765_4321_F00D_BEEF, 1);
    do_load("lw4", 5'd12, 1'b1, 3'b010, 3'd4, 64'h8765_4321_F00D_BEEF, 2);
    do_load("ld7", 5'd13, 1'b1, 3'b011, 3'd7, 64'h8765_4321_F00D_BEEF, 0);
    do_load("f111", 5'd14, 1'b1, 3'b111, 3'd6, 64'hFEDC_BA98_7654_3210, 0);
    do_load("lh_rd0", 5'd0, 1'b1, 3'b001, 3'd2, 64'h0000_0000_8001_0000, 1);

    // Randomized loads
    for (int i = 0; i < 40; i++) begin
      do_load("rnd_ld", 5'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
              {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    // Reset while a load waits, with a response arriving in the same cycle
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; ex_wen = 1'b1;
    ex_load_fmt = 3'b011; ex_byte_off = 3'd0;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    check("rst_ld.busy", {63'd0, busy_valid}, 64'd1);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA;
    #1;
    check("rst_ld.ready_in_rst", {63'd0, ex_ready}, 64'd0);
    check("rst_ld.rready_in_rst", {63'd0, mem_rready}, 64'd0);
    step();
    rst = 1'b1; mem_rvalid = 1'b0;
    #1;
    check("rst_ld.wen", {63'd0, rf_wen}, 64'd0);
    check("rst_ld.busy_clr", {63'd0, busy_valid}, 64'd0);
    check("rst_ld.busy_rd", {59'd0, busy_rd}, 64'd0);
    check("rst_ld.ready", {63'd0, ex_ready}, 64'd1);
    check("rst_ld.rready", {63'd0, mem_rready}, 64'd0);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("rst_ld.no_late_wen", {63'd0, rf_wen}, 64'd0);

`ifdef WB_RETIRE_CNT_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("cnt.reset", retire_cnt, 64'd0);
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1'b1; ex_wen = 1'b1; ex_result = 64'(i);
      ex_rd = (i == 2) ? 5'd0 : 5'(i + 3);
      step();
    end
    ex_valid = 1'b0;
    step();
    step();
    check("cnt.four", retire_cnt, 64'd4);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("cnt.cleared", retire_cnt, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
